// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below 0x8000_0000, MMIO above it
// (console FIFO, cycle counter, halt register). Reads are combinational.
module dmem_responder #(
   parameter int MEM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d_mem_w_addr,
   input  logic [31:0] d_mem_w_data,
   input  logic        d_mem_we,
   input  logic        d_mem_oe,
   output logic [31:0] d_mem_r_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        halted,
   output logic [31:0] halt_code
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] REG_TX     = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CYCLE  = 2'd2;
   localparam logic [1:0] REG_HALT   = 2'd3;

   logic [31:0]   mem_q [MEM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          halted_q, halted_d;
   logic [31:0]   cycle_q, cycle_d;
   logic [31:0]   halt_code_q, halt_code_d;

   logic          is_mmio;
   logic [1:0]    reg_sel;
   logic [AW-1:0] ram_idx;
   logic          fifo_full;
   logic          ram_we;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          halt_we;
   logic          unused_addr_bits;

   assign is_mmio   = d_mem_w_addr[31];
   assign reg_sel   = d_mem_w_addr[3:2];
   assign ram_idx   = d_mem_w_addr[AW+1:2];
   assign unused_addr_bits = ^{d_mem_w_addr[30:AW+2], d_mem_w_addr[1:0]};

   assign fifo_full = (count_q == (PW+1)'(FIFO_DEPTH));
   assign tx_valid  = (count_q != '0);
   assign tx_data   = fifo_q[rd_ptr_q];
   assign halted    = halted_q;
   assign halt_code = halt_code_q;

   // Once halted, the core can no longer change RAM or the console stream.
   assign ram_we   = d_mem_we & ~is_mmio & ~halted_q;
   assign push_req = d_mem_we & is_mmio & (reg_sel == REG_TX) & ~halted_q;
   assign push_ok  = push_req & ~fifo_full;
   assign pop      = tx_valid & tx_ready;
   assign halt_we  = d_mem_we & is_mmio & (reg_sel == REG_HALT) & ~halted_q;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (push_req & fifo_full);
      halted_d    = halted_q | halt_we;
      halt_code_d = halt_we ? d_mem_w_data : halt_code_q;
      cycle_d     = halted_q ? cycle_q : cycle_q + 32'd1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         halted_q    <= 1'b0;
         cycle_q     <= '0;
         halt_code_q <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         halted_q    <= halted_d;
         cycle_q     <= cycle_d;
         halt_code_q <= halt_code_d;
      end
   end

   // Storage arrays keep their contents across reset.
   always_ff @(posedge clk) begin
      if (ram_we)  mem_q[ram_idx]   <= d_mem_w_data;
      if (push_ok) fifo_q[wr_ptr_q] <= d_mem_w_data[7:0];
   end

   always_comb begin
      d_mem_r_data = '0;
      if (d_mem_oe) begin
         if (!is_mmio) begin
            d_mem_r_data = mem_q[ram_idx];
         end else begin
            case (reg_sel)
               REG_STATUS: d_mem_r_data = {16'h0, 8'(count_q), 4'h0, halted_q,
                                           overflow_q, ~tx_valid, fifo_full};
               REG_CYCLE:  d_mem_r_data = cycle_q;
               default:    d_mem_r_data = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: RAM/MMIO model, console byte scoreboard and
// cycle/halt model, all checked through one task.
module tb_dmem_responder;

   localparam int MEM_WORDS  = 1024;
   localparam int FIFO_DEPTH = 8;

   localparam logic [31:0] A_TX     = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0004;
   localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
   localparam logic [31:0] A_HALT   = 32'h8000_000C;

   logic        clk;
   logic        rst_n;
   logic [31:0] d_mem_w_addr;
   logic [31:0] d_mem_w_data;
   logic        d_mem_we;
   logic        d_mem_oe;
   logic [31:0] d_mem_r_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        halted;
   logic [31:0] halt_code;

   dmem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d_mem_w_addr (d_mem_w_addr),
      .d_mem_w_data (d_mem_w_data),
      .d_mem_we     (d_mem_we),
      .d_mem_oe     (d_mem_oe),
      .d_mem_r_data (d_mem_r_data),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .halted       (halted),
      .halt_code    (halt_code)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] ram_m [int];
   logic        ovf_m = 1'b0;
   logic        halted_m = 1'b0;
   logic [31:0] halt_code_m = '0;
   logic [31:0] cyc_m = '0;
   logic        pop_pend = 1'b0;
   logic        push_pend = 1'b0;
   logic [7:0]  push_byte = '0;
   logic        halt_pend = 1'b0;
   logic [31:0] halt_data = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] status_m();
      int n;
      n = exp_q.size();
      return {16'h0, 8'(n), 4'h0, halted_m, ovf_m, (n == 0), (n == FIFO_DEPTH)};
   endfunction

   // Model state commits on the same edge the DUT commits.
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc_m = '0;
         pop_pend = 1'b0;
         push_pend = 1'b0;
         halt_pend = 1'b0;
      end else begin
         if (!halted_m) cyc_m = cyc_m + 32'd1;
         if (pop_pend) void'(exp_q.pop_front());
         if (push_pend) exp_q.push_back(push_byte);
         if (halt_pend) begin
            halted_m = 1'b1;
            halt_code_m = halt_data;
         end
         pop_pend = 1'b0;
         push_pend = 1'b0;
         halt_pend = 1'b0;
      end
   end

   // Console monitor: samples between drive time and the next rising edge.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
         if (tx_valid && tx_ready && exp_q.size() != 0) begin
            check("tx_data", 32'(tx_data), 32'(exp_q[0]));
            pop_pend = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic we, input logic oe, input logic [31:0] addr,
                        input logic [31:0] data, input logic rdy);
      @(negedge clk);
      d_mem_we = we;
      d_mem_oe = oe;
      d_mem_w_addr = addr;
      d_mem_w_data = data;
      tx_ready = rdy;
      if (we && rst_n && !halted_m && !halt_pend) begin
         if (!addr[31]) begin
            ram_m[int'(addr[11:2])] = data;
         end else if (addr[3:2] == 2'd0) begin
            if (exp_q.size() == FIFO_DEPTH) ovf_m = 1'b1;
            else begin
               push_pend = 1'b1;
               push_byte = data[7:0];
            end
         end else if (addr[3:2] == 2'd3) begin
            halt_pend = 1'b1;
            halt_data = data;
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0, rdy);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      drive(1'b0, 1'b1, addr, 32'h0, 1'b0);
      check(tag, d_mem_r_data, exp);
   endtask

   task automatic rd_status(input string tag, input logic [31:0] addr);
      drive(1'b0, 1'b1, addr, 32'h0, 1'b0);
      check(tag, d_mem_r_data, status_m());
   endtask

   task automatic rd_cycle(input string tag);
      drive(1'b0, 1'b1, A_CYCLE, 32'h0, 1'b0);
      check(tag, d_mem_r_data, cyc_m);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      d_mem_we = 1'b0;
      d_mem_oe = 1'b0;
      tx_ready = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      halted_m = 1'b0;
      halt_code_m = '0;
      cyc_m = '0;
      pop_pend = 1'b0;
      push_pend = 1'b0;
      halt_pend = 1'b0;
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_halt_code", halt_code, 32'h0);
      d_mem_oe = 1'b1;
      d_mem_w_addr = A_STATUS;
      #1;
      check("rst_status", d_mem_r_data, 32'h0000_0002);
      d_mem_oe = 1'b0;
      #1;
      check("rst_oe_low", d_mem_r_data, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] ra [8];
      logic [31:0] old;
      rst_n = 1'b0;
      d_mem_w_addr = '0;
      d_mem_w_data = '0;
      d_mem_we = 1'b0;
      d_mem_oe = 1'b0;
      tx_ready = 1'b0;
      apply_reset();

      // cycle counter: read after the fifth edge following release
      idle(4, 1'b0);
      drive(1'b0, 1'b1, A_CYCLE, 32'h0, 1'b0);
      check("cycle_5", d_mem_r_data, 32'd5);
      rd_cycle("cycle_run");

      // RAM basics, wrap, oe gating, read-during-write
      drive(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_wrap", 32'h0000_0010 + 4 * MEM_WORDS, 32'hDEAD_BEEF);
      drive(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
      check("ram_oe_low", d_mem_r_data, 32'h0);
      old = ram_m[4];
      drive(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
      check("ram_rdw_old", d_mem_r_data, old);
      rd("ram_rdw_new", 32'h0000_0010, 32'h1234_5678);

      for (int i = 0; i < 8; i++) begin
         ra[i] = $urandom & 32'h7FFF_FFFF;
         drive(1'b1, 1'b0, ra[i], $urandom, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         rd("ram_rand", ra[i], ram_m[int'(ra[i][11:2])]);
      end

      // read-only / write-only register behaviour, MMIO alias
      rd("tx_reads_zero", A_TX, 32'h0);
      rd("halt_reads_zero", A_HALT, 32'h0);
      drive(1'b1, 1'b0, A_STATUS, 32'hFFFF_FFFF, 1'b0);
      drive(1'b1, 1'b0, A_CYCLE, 32'h0, 1'b0);
      rd_status("status_ro", A_STATUS);
      rd_status("status_alias", 32'hFFFF_FFF4);
      rd_cycle("cycle_ro");

      // console: "Hi"
      drive(1'b1, 1'b0, A_TX, 32'h48, 1'b0);
      drive(1'b1, 1'b0, A_TX, 32'h69, 1'b0);
      drive(1'b0, 1'b1, A_STATUS, 32'h0, 1'b0);
      check("hi_status", d_mem_r_data, 32'h0000_0200);
      check("hi_valid", 32'(tx_valid), 32'h1);
      check("hi_data", 32'(tx_data), 32'h48);
      idle(2, 1'b1);
      drive(1'b0, 1'b1, A_STATUS, 32'h0, 1'b0);
      check("hi_drained_status", d_mem_r_data, 32'h0000_0002);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < FIFO_DEPTH; i++) drive(1'b1, 1'b0, A_TX, 32'h10 + i, 1'b0);
      rd_status("full_status", A_STATUS);
      drive(1'b1, 1'b0, A_TX, 32'hAA, 1'b1);
      rd("full_pushpop_status", A_STATUS, 32'h0000_0704);
      idle(FIFO_DEPTH - 1, 1'b1);
      rd_status("full_drained", A_STATUS);

      // overflow: push FIFO_DEPTH+1 bytes
      for (int i = 0; i <= FIFO_DEPTH; i++) drive(1'b1, 1'b0, A_TX, i, 1'b0);
      rd("ovf_status", A_STATUS, 32'h0000_0805);
      idle(FIFO_DEPTH, 1'b1);
      rd("ovf_drained", A_STATUS, 32'h0000_0006);

      // halt
      drive(1'b1, 1'b0, 32'h0, 32'h0000_1111, 1'b0);
      drive(1'b1, 1'b0, A_TX, 32'h41, 1'b0);
      drive(1'b1, 1'b0, A_HALT, 32'h0000_002A, 1'b0);
      idle(1, 1'b0);
      check("halted", 32'(halted), 32'h1);
      check("halt_code", halt_code, 32'h0000_002A);
      rd_cycle("cycle_frozen_a");
      idle(3, 1'b0);
      rd_cycle("cycle_frozen_b");
      drive(1'b1, 1'b0, 32'h0, 32'h0000_5555, 1'b0);
      rd("ram_after_halt", 32'h0, 32'h0000_1111);
      drive(1'b1, 1'b0, A_HALT, 32'h1, 1'b0);
      idle(1, 1'b0);
      check("halt_code_kept", halt_code, 32'h0000_002A);
      drive(1'b1, 1'b0, A_TX, 32'h77, 1'b0);
      rd("halt_push_ignored", A_STATUS, 32'h0000_010C);
      idle(1, 1'b1);
      rd("halt_drained", A_STATUS, 32'h0000_000E);

      // reset in the middle of a drain
      apply_reset();
      drive(1'b1, 1'b0, A_TX, 32'h31, 1'b0);
      drive(1'b1, 1'b0, A_TX, 32'h32, 1'b0);
      drive(1'b1, 1'b0, A_TX, 32'h33, 1'b0);
      idle(1, 1'b1);
      apply_reset();
      drive(1'b0, 1'b1, A_STATUS, 32'h0, 1'b0);
      check("post_rst_status", d_mem_r_data, 32'h0000_0002);
      check("post_rst_halted", 32'(halted), 32'h0);
      idle(1, 1'b0);
      drive(1'b0, 1'b1, A_CYCLE, 32'h0, 1'b0);
      check("post_rst_cycle", d_mem_r_data, 32'd3);

      idle(2, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable responder for the core's data-memory port; replaces the behavioural data memory used in simulation.
- Provides a word-addressed RAM region and a small MMIO region:
  - a console byte FIFO drained over a valid/ready output;
  - a free-running cycle counter;
  - a halt register that ends a program run.
- Sits between core (initiator) and top-level/test harness.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8: console FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_mem_w_addr  in  32  byte address for read and write (core's only data address).
- d_mem_w_data  in  32  write data.
- d_mem_we  in  1  write strobe, sampled at rising edge.
- d_mem_oe  in  1  read enable.
- d_mem_r_data  out  32  combinational read data.
- tx_valid  out  1  console FIFO non-empty.
- tx_data  out  8  console FIFO head byte.
- tx_ready  in  1  consumer accepts head byte.
- halted  out  1  program has written HALT.
- halt_code  out  32  value written to HALT.

Behaviour:
- Address map:
  - addr[31]=0 selects RAM, word index addr[log2(MEM_WORDS)+1:2]; upper bits ignored, so the index wraps modulo MEM_WORDS.
  - addr[31]=1 selects MMIO, decoded on addr[3:2], other bits ignored:
    - 0 CONSOLE_TX (W): push addr data[7:0].
    - 1 STATUS (R): bit0 fifo_full, bit1 fifo_empty, bit2 overflow (sticky), bit3 halted, bits[15:8] fifo count, rest 0.
    - 2 CYCLE (R): cycle counter.
    - 3 HALT (W): halt.
  - addr[1:0] ignored; word accesses only.
- Reads:
  - Combinational, zero latency.
  - d_mem_r_data=0 when d_mem_oe=0.
  - Writes to RO registers and reads of WO registers have no effect and return 0.
  - RAM read in the same cycle as a write to the same word returns the old word; the new word is visible the next cycle.
- Writes: take effect at the rising edge where d_mem_we=1. Once halted=1, all RAM writes and console pushes are ignored.
- Console FIFO:
  - Show-ahead: tx_data = head entry, tx_valid = (count != 0).
  - A byte pushed at edge N is visible on tx_valid/tx_data after edge N.
  - Pop when tx_valid & tx_ready at a rising edge.
  - Push and pop in the same edge: both occur, count unchanged.
  - Push while count==FIFO_DEPTH (pre-edge count): byte dropped and overflow set, even if a pop happens the same edge.
  - overflow clears only on reset.
  - tx_data is don't-care when tx_valid=0. Pointers wrap modulo FIFO_DEPTH.
- Cycle counter:
  - 32 bits; increments every edge while rst_n=1 and halted=0; wraps 0xFFFFFFFF->0.
  - Reads return the pre-increment value of the current cycle.
  - Freezes when halted.
- Halt:
  - The first write to HALT sets halted=1 and latches halt_code=data at that edge.
  - Later HALT writes are ignored.
  - Console draining continues after halt.
- Reset (asynchronous, rst_n=0, including mid-transfer):
  - FIFO emptied, so tx_valid=0 immediately.
  - overflow=0, cycle=0, halted=0, halt_code=0.
  - d_mem_r_data follows the read rules.
  - RAM contents are not reset.
- Reset release is synchronised by the integrator; state begins updating from the first rising edge with rst_n=1.

Test Plan:
- RAM write 0xDEADBEEF to 0x0000_0010, then oe read 0x10 -> 0xDEADBEEF; read 0x10+4*MEM_WORDS -> 0xDEADBEEF (wrap); oe=0 -> 0x00000000.
- Push 'H','i' (0x48, 0x69) with tx_ready=0 -> tx_valid=1, tx_data=0x48, STATUS=0x0000_0200; raise tx_ready for 2 cycles -> 0x48 then 0x69 consumed, tx_valid=0, STATUS=0x0000_0002.
- Push FIFO_DEPTH+1 bytes 0..8 with tx_ready=0 -> STATUS bit0=1, bit2=1, count=8; drained sequence is 0..7 (byte 8 dropped).
- Full FIFO with simultaneous push and pop -> pushed byte dropped, overflow set, count 7 after edge.
- Read CYCLE 5 edges after reset release -> 5; write HALT 0x0000_002A -> halted=1, halt_code=0x2A; CYCLE frozen; later RAM write to 0x0 not stored; second HALT 0x1 keeps 0x2A.
- Assert rst_n low mid-drain with 3 bytes queued -> tx_valid=0 immediately without clock; after release STATUS=0x0000_0002, halted=0, CYCLE counts from 0.
